dmem_responder: RTL and testbench

//  Memory-side responder for the datapath's data-memory port. Accepts load/store

---
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word storage behind a wait-state FSM, with alignment/range error reporting.
// Optional byte-lane access is enabled by defining DMEM_BYTE_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
`ifdef DMEM_BYTE_EN
  input  logic        ByteAcc,
`endif
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemErr
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        accept;

  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        misaligned;
  logic        out_of_range;
  logic        err;
  logic        commit;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0] rd_word;
  logic [31:0] load_val;

  logic [31:0] mem [DEPTH];

  assign accept = (state == S_IDLE) && MemReq;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (MemReq) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt <= 4'd1) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                 cnt <= 4'd0;
    else if (accept)           cnt <= WAIT_INIT;
    else if (state == S_WAIT)  cnt <= cnt - 4'd1;
  end

  // Request fields are captured once at acceptance; the requester may change them afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= MemWrite;
      addr_q  <= Addr;
      wdata_q <= WriteData;
    end
  end

`ifdef DMEM_BYTE_EN
  logic       byte_q;
  logic [4:0] lane_sh;

  always_ff @(posedge clk) begin
    if (accept) byte_q <= ByteAcc;
  end

  assign lane_sh    = {addr_q[1:0], 3'b000};
  assign misaligned = (addr_q[1:0] != 2'b00) && !byte_q;
  assign load_val   = byte_q ? {24'd0, rd_word[lane_sh +: 8]} : rd_word;
`else
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign load_val   = rd_word;
`endif

  assign out_of_range = |addr_q[31:DEPTH_LOG2+2];
  assign err          = misaligned || out_of_range;
  assign word_idx     = addr_q[DEPTH_LOG2+1:2];
  assign rd_word      = mem[word_idx];

  // A reset coinciding with RESP still cancels the store.
  assign commit = (state == S_RESP) && write_q && !err && !reset;

  always_ff @(posedge clk) begin
    if (commit) begin
`ifdef DMEM_BYTE_EN
      if (byte_q) mem[word_idx][lane_sh +: 8] <= wdata_q[7:0];
      else        mem[word_idx]               <= wdata_q;
`else
      mem[word_idx] <= wdata_q;
`endif
    end
  end

  assign MemReady = (state == S_RESP);
  assign MemBusy  = (state != S_IDLE);
  assign MemErr   = MemReady && err;
  assign ReadData = (MemReady && !err) ? load_val : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, MemReq0;
  logic        MemWrite;
  logic [31:0] Addr, WriteData;
  logic        ByteAcc;
  logic [31:0] ReadData, ReadData0;
  logic        MemReady, MemBusy, MemErr;
  logic        MemReady0, MemBusy0, MemErr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData),
`ifdef DMEM_BYTE_EN
    .ByteAcc(ByteAcc),
`endif
    .ReadData(ReadData), .MemReady(MemReady), .MemBusy(MemBusy), .MemErr(MemErr)
  );

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .MemReq(MemReq0), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData),
`ifdef DMEM_BYTE_EN
    .ByteAcc(ByteAcc),
`endif
    .ReadData(ReadData0), .MemReady(MemReady0), .MemBusy(MemBusy0), .MemErr(MemErr0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on the main instance and check the full response window.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic bacc,
                        input logic exp_err, input logic [31:0] exp_rd);
    @(negedge clk);
    MemReq = 1'b1; MemWrite = wr; Addr = a; WriteData = d; ByteAcc = bacc;
    @(posedge clk);
    #1 MemReq = 1'b0; Addr = 32'hFFFF_FFFF; WriteData = 32'h0BAD_0BAD; ByteAcc = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k <= W) begin
        check({tag, "_wait_ready"}, MemReady, 1'b0);
        check({tag, "_wait_busy"}, MemBusy, 1'b1);
      end else if (k == W + 1) begin
        check({tag, "_ready"}, MemReady, 1'b1);
        check({tag, "_err"}, MemErr, exp_err);
        if (!wr || exp_err) check({tag, "_rdata"}, ReadData, exp_rd);
      end else begin
        check({tag, "_after_ready"}, MemReady, 1'b0);
        check({tag, "_after_busy"}, MemBusy, 1'b0);
        check({tag, "_after_rdata"}, ReadData, 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; MemReq = 1'b0; MemReq0 = 1'b0; MemWrite = 1'b0;
    Addr = 32'd0; WriteData = 32'd0; ByteAcc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", MemReady, 1'b0);
    check("rst_busy", MemBusy, 1'b0);
    check("rst_err", MemErr, 1'b0);
    check("rst_rdata", ReadData, 32'd0);
    reset = 1'b0;

    // Store then load the same word
    do_req("t1_st", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    do_req("t1_ld", 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // Misaligned store is rejected and leaves storage intact
    do_req("t2_st", 1'b1, 32'h12, 32'h1111_2222, 1'b0, 1'b1, 32'd0);
    do_req("t2_ld", 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // Out-of-range load (word 64)
    do_req("t3_ld", 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 32'd0);

    // Request while busy is dropped
    do_req("t4_pre", 1'b1, 32'h14, 32'h1111_1111, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b0; Addr = 32'h10;
    @(posedge clk);
    #1 MemReq = 1'b0;
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h14; WriteData = 32'h7777_7777;
    check("t4_c1_busy", MemBusy, 1'b1);
    @(posedge clk);
    #1 MemReq = 1'b0;
    @(negedge clk);
    check("t4_c2_ready", MemReady, 1'b0);
    @(negedge clk);
    check("t4_c3_ready", MemReady, 1'b1);
    check("t4_c3_rdata", ReadData, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t4_c4_ready", MemReady, 1'b0);
    check("t4_c4_busy", MemBusy, 1'b0);
    @(negedge clk);
    check("t4_c5_ready", MemReady, 1'b0);
    do_req("t4_ld", 1'b0, 32'h14, 32'd0, 1'b0, 1'b0, 32'h1111_1111);

    // Reset during WAIT aborts a store with no response
    do_req("t5_pre", 1'b1, 32'h20, 32'h0000_5555, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'h0000_1234;
    @(posedge clk);
    #1 MemReq = 1'b0;
    @(negedge clk);
    check("t5_c1_busy", MemBusy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_busy", MemBusy, 1'b0);
    check("t5_rst_ready", MemReady, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_ready", MemReady, 1'b0);
    end
    do_req("t5_ld", 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'h0000_5555);

    // Zero wait states: response in cycle 1
    @(negedge clk);
    MemReq0 = 1'b1; MemWrite = 1'b1; Addr = 32'h8; WriteData = 32'hCAFE_F00D;
    @(posedge clk);
    #1 MemReq0 = 1'b0;
    @(negedge clk);
    check("t6_st_ready", MemReady0, 1'b1);
    check("t6_st_err", MemErr0, 1'b0);
    MemReq0 = 1'b1; MemWrite = 1'b0; Addr = 32'h8;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_resp_idle_ready", MemReady0, 1'b0);
    @(posedge clk);
    #1 MemReq0 = 1'b0;
    @(negedge clk);
    check("t6_ld_ready", MemReady0, 1'b1);
    check("t6_ld_rdata", ReadData0, 32'hCAFE_F00D);
    @(negedge clk);
    check("t6_after_ready", MemReady0, 1'b0);

`ifdef DMEM_BYTE_EN
    // Byte lane store and load
    do_req("b_st", 1'b1, 32'h11, 32'h0000_00AB, 1'b1, 1'b0, 32'd0);
    do_req("b_ldw", 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'hDEAD_ABEF);
    do_req("b_ldb", 1'b0, 32'h13, 32'd0, 1'b1, 1'b0, 32'h0000_00DE);
    do_req("b_oor", 1'b0, 32'h101, 32'd0, 1'b1, 1'b1, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
